// File: rtl/spi_frame_master.sv
// SPI mode-0 master that reads a 96-bit measurement frame (fs_cnt, fx_cnt, reference word)
// MSB first, checks the reference word and publishes the counts only from good frames.
module spi_frame_master #(
  parameter int          CLK_DIV    = 8,
  parameter int          FRAME_BITS = 96,
  parameter logic [31:0] REF_WORD   = 32'd200_000_000,
  parameter int          IDLE_GAP   = 16
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        MISO,
  output logic        nCS,
  output logic        SCK,
  output logic        busy,
  output logic        done,
  output logic        frame_ok,
  output logic [31:0] fs_cnt,
  output logic [31:0] fx_cnt,
  output logic [31:0] ref_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(IDLE_GAP - 1);
  localparam logic [6:0]  BIT_LAST = 7'(FRAME_BITS);

  // Handshake: start is a level sampled only in IDLE (no ready); busy covers the whole
  // frame plus the inter-frame gap, and done is a single-cycle pulse as nCS rises.
  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [6:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic                    ncs_q, ncs_d;
  logic                    sck_q, sck_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    frame_ok_q, frame_ok_d;
  logic [31:0]             fs_q, fs_d;
  logic [31:0]             fx_q, fx_d;
  logic [31:0]             ref_q, ref_d;
  logic                    miso_meta_q, miso_s_q;
  logic                    div_last;
  logic [6:0]              bit_next;
  logic                    ref_match;

  assign div_last  = (cnt_q == DIV_LAST);
  assign bit_next  = bit_cnt_q + 7'd1;
  assign ref_match = (sr_q[31:0] == REF_WORD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    ncs_d      = ncs_q;
    sck_d      = sck_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    frame_ok_d = frame_ok_q;
    fs_d       = fs_q;
    fx_d       = fx_q;
    ref_d      = ref_q;
    unique case (state_q)
      S_IDLE: begin
        ncs_d  = 1'b1;
        sck_d  = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d   = S_SETUP;
          ncs_d     = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = 16'd0;
          bit_cnt_d = 7'd0;
        end
      end
      S_SETUP, S_LOW: begin
        if (div_last) begin
          cnt_d   = 16'd0;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HIGH: begin
        // Sample on the last cycle of the high phase: the slave shifted on the previous
        // falling edge, so its data has had a full half-period to cross both syncs.
        if (div_last) begin
          cnt_d     = 16'd0;
          sck_d     = 1'b0;
          sr_d      = {sr_q[FRAME_BITS-2:0], miso_s_q};
          bit_cnt_d = bit_next;
          state_d   = (bit_next == BIT_LAST) ? S_HOLD : S_LOW;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (div_last) begin
          cnt_d      = 16'd0;
          ncs_d      = 1'b1;
          done_d     = 1'b1;
          ref_d      = sr_q[31:0];
          frame_ok_d = ref_match;
          if (ref_match) begin
            fs_d = sr_q[95:64];
            fx_d = sr_q[63:32];
          end
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 16'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ncs_d   = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bit_cnt_q   <= 7'd0;
      sr_q        <= '0;
      ncs_q       <= 1'b1;
      sck_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      fs_q        <= 32'd0;
      fx_q        <= 32'd0;
      ref_q       <= 32'd0;
      miso_meta_q <= 1'b0;
      miso_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      ncs_q       <= ncs_d;
      sck_q       <= sck_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_ok_q  <= frame_ok_d;
      fs_q        <= fs_d;
      fx_q        <= fx_d;
      ref_q       <= ref_d;
      miso_meta_q <= MISO;
      miso_s_q    <= miso_meta_q;
    end
  end

  assign nCS      = ncs_q;
  assign SCK      = sck_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign frame_ok = frame_ok_q;
  assign fs_cnt   = fs_q;
  assign fx_cnt   = fx_q;
  assign ref_cnt  = ref_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: two instances (CLK_DIV 8 and 255) each talking to a mode-0
// slave model; frames are compared against a reference model of the published outputs.
module tb_spi_frame_master;

  localparam logic [31:0] REF      = 32'h0BEBC200;
  localparam int          IDLE_GAP = 16;
  localparam int          DIV0     = 8;
  localparam int          DIV1     = 255;

  // clock / reset
  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [1:0]  start = 2'b00;
  logic [1:0]  miso;
  logic [1:0]  ncs, sck, busy, done, frame_ok;
  logic [31:0] fs_cnt [2];
  logic [31:0] fx_cnt [2];
  logic [31:0] ref_cnt [2];

  spi_frame_master #(.CLK_DIV(DIV0), .FRAME_BITS(96), .REF_WORD(REF), .IDLE_GAP(IDLE_GAP)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start[0]), .MISO(miso[0]),
    .nCS(ncs[0]), .SCK(sck[0]), .busy(busy[0]), .done(done[0]), .frame_ok(frame_ok[0]),
    .fs_cnt(fs_cnt[0]), .fx_cnt(fx_cnt[0]), .ref_cnt(ref_cnt[0])
  );

  spi_frame_master #(.CLK_DIV(DIV1), .FRAME_BITS(96), .REF_WORD(REF), .IDLE_GAP(IDLE_GAP)) dut_slow (
    .sys_clk(sys_clk), .rst(rst), .start(start[1]), .MISO(miso[1]),
    .nCS(ncs[1]), .SCK(sck[1]), .busy(busy[1]), .done(done[1]), .frame_ok(frame_ok[1]),
    .fs_cnt(fs_cnt[1]), .fx_cnt(fx_cnt[1]), .ref_cnt(ref_cnt[1])
  );

  // Slave model: mode 0, MSB first, 2-FF SCK sync, shifts on the synced falling edge,
  // reloads its frame whenever nCS is high.
  logic [95:0] slave_frame [2];
  logic [95:0] slave_sr [2];
  logic [2:0]  sck_sync [2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      slave_frame[i] = '0;
      slave_sr[i]    = '0;
      sck_sync[i]    = '0;
    end
  end
  always @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      sck_sync[i] <= {sck_sync[i][1:0], sck[i]};
      if (ncs[i]) slave_sr[i] <= slave_frame[i];
      else if (sck_sync[i][2:1] == 2'b10) slave_sr[i] <= {slave_sr[i][94:0], 1'b0};
    end
  end
  assign miso[0] = slave_sr[0][95];
  assign miso[1] = slave_sr[1][95];

  // Bus monitor, sampled on the falling clock edge.
  int   low_run [2]       = '{0, 0};
  int   low_last [2]      = '{0, 0};
  int   high_run [2]      = '{0, 0};
  int   high_last [2]     = '{0, 0};
  int   rises_cur [2]     = '{0, 0};
  int   rise_last [2]     = '{0, 0};
  int   idle_edges [2]    = '{0, 0};
  int   done_total [2]    = '{0, 0};
  int   done_bad [2]      = '{0, 0};
  int   busy_bad [2]      = '{0, 0};
  int   busy_low_run [2]  = '{0, 0};
  int   busy_low_last [2] = '{0, 0};
  logic ncs_prev [2]      = '{1'b1, 1'b1};
  logic sck_prev [2]      = '{1'b0, 1'b0};
  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ncs[i]) begin
        if (ncs_prev[i]) begin
          high_last[i] = high_run[i];
          low_run[i]   = 0;
          rises_cur[i] = 0;
        end
        low_run[i]++;
        if (sck[i] && !sck_prev[i]) rises_cur[i]++;
        high_run[i] = 0;
      end else begin
        if (!ncs_prev[i]) begin
          low_last[i]  = low_run[i];
          rise_last[i] = rises_cur[i];
          high_run[i]  = 0;
        end
        high_run[i]++;
        if (ncs_prev[i] && (sck[i] != sck_prev[i])) idle_edges[i]++;
      end
      if (done[i]) begin
        done_total[i]++;
        if (!(ncs[i] && !ncs_prev[i])) done_bad[i]++;
      end
      if (!busy[i] && !ncs[i]) busy_bad[i]++;
      if (!busy[i]) busy_low_run[i]++;
      else begin
        if (busy_low_run[i] > 0) busy_low_last[i] = busy_low_run[i];
        busy_low_run[i] = 0;
      end
      ncs_prev[i] = ncs[i];
      sck_prev[i] = sck[i];
    end
  end

  // Scoreboard: frames queued in send order, reference model of the published outputs.
  logic [95:0] exp_q[$];
  logic [95:0] exp_q_slow[$];
  logic [31:0] model_fs [2]  = '{32'd0, 32'd0};
  logic [31:0] model_fx [2]  = '{32'd0, 32'd0};
  logic [31:0] model_ref [2] = '{32'd0, 32'd0};
  logic [31:0] model_ok [2]  = '{32'd0, 32'd0};
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [95:0] rand_frame();
    logic [31:0] rf;
    rf = ($urandom_range(0, 1) == 1) ? REF : (REF ^ (32'd1 << $urandom_range(0, 31)));
    return {32'($urandom()), 32'($urandom()), rf};
  endfunction

  // drivers
  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!busy[i]) begin got = 1'b1; break; end
      tick();
    end
    chk("idle_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input int i, input int budget);
    logic got;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done[i]) begin got = 1'b1; break; end
    end
    chk("done_timeout", 32'(got), 32'd1);
  endtask

  task automatic send_frame(input int i, input logic [95:0] f);
    wait_idle(i);
    slave_frame[i] = f;
    if (i == 0) exp_q.push_back(f);
    else exp_q_slow.push_back(f);
    pulse_start(i);
  endtask

  task automatic check_frame(input int i, input string tag);
    logic [95:0] f;
    int div;
    div = (i == 0) ? DIV0 : DIV1;
    if (i == 0) f = exp_q.pop_front();
    else f = exp_q_slow.pop_front();
    model_ref[i] = f[31:0];
    model_ok[i]  = (f[31:0] == REF) ? 32'd1 : 32'd0;
    if (f[31:0] == REF) begin
      model_fs[i] = f[95:64];
      model_fx[i] = f[63:32];
    end
    chk({tag, "_fs"}, fs_cnt[i], model_fs[i]);
    chk({tag, "_fx"}, fx_cnt[i], model_fx[i]);
    chk({tag, "_ref"}, ref_cnt[i], model_ref[i]);
    chk({tag, "_ok"}, 32'(frame_ok[i]), model_ok[i]);
    chk({tag, "_ncs_low"}, 32'(low_last[i]), 32'(193 * div));
    chk({tag, "_sck_rises"}, 32'(rise_last[i]), 32'd96);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ncs"}, 32'(ncs[0]), 32'd1);
    chk({tag, "_sck"}, 32'(sck[0]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[0]), 32'd0);
    chk({tag, "_done"}, 32'(done[0]), 32'd0);
    chk({tag, "_ok"}, 32'(frame_ok[0]), 32'd0);
    chk({tag, "_fs"}, fs_cnt[0], 32'd0);
    chk({tag, "_fx"}, fx_cnt[0], 32'd0);
    chk({tag, "_ref"}, ref_cnt[0], 32'd0);
  endtask

  initial begin
    int d0;
    logic got;
    logic [95:0] fn;

    // reset state
    ticks(3);
    check_cleared("reset");
    chk("reset_slow_ncs", 32'(ncs[1]), 32'd1);
    rst = 1'b0;
    tick();

    // basic frame
    send_frame(0, {32'h00001234, 32'h00000ABC, REF});
    wait_done(0, 3000);
    check_frame(0, "basic");

    // bad reference word keeps the previous counts
    send_frame(0, {32'hFFFFFFFF, 32'($urandom()), 32'h0BEBC1FF});
    wait_done(0, 3000);
    check_frame(0, "badref");

    // bit-order patterns
    send_frame(0, {32'hAAAAAAAA, 32'h55555555, REF});
    wait_done(0, 3000);
    check_frame(0, "alt");
    send_frame(0, {32'h80000001, 32'h00000001, REF});
    wait_done(0, 3000);
    check_frame(0, "edge_bits");

    // random frames, good and corrupted reference words
    for (int n = 0; n < 3; n++) begin
      send_frame(0, rand_frame());
      wait_done(0, 3000);
      check_frame(0, "rand");
    end

    // start held high: three back-to-back frames
    wait_idle(0);
    d0 = done_total[0];
    fn = rand_frame();
    slave_frame[0] = fn;
    exp_q.push_back(fn);
    start[0] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_done(0, 3000);
      if (f == 2) start[0] = 1'b0;
      else begin
        fn = rand_frame();
        slave_frame[0] = fn;
        exp_q.push_back(fn);
      end
      check_frame(0, "held");
      if (f > 0) begin
        chk("held_gap", 32'(high_last[0]), 32'(IDLE_GAP + 1));
        chk("held_busy_low", 32'(busy_low_last[0]), 32'd1);
      end
    end
    ticks(IDLE_GAP + 30);
    chk("held_done_count", 32'(done_total[0] - d0), 32'd3);
    chk("held_ncs_idle", 32'(ncs[0]), 32'd1);

    // extra start pulses while busy are ignored
    d0 = done_total[0];
    send_frame(0, rand_frame());
    for (int n = 0; n < 3; n++) begin
      ticks($urandom_range(50, 400));
      pulse_start(0);
    end
    wait_done(0, 3000);
    check_frame(0, "extra_start");
    ticks(IDLE_GAP + 30);
    chk("extra_done_count", 32'(done_total[0] - d0), 32'd1);
    chk("extra_ncs_idle", 32'(ncs[0]), 32'd1);

    // reset at the 40th SCK rise
    send_frame(0, {32'h13572468, 32'h0F0F0F0F, REF});
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (!ncs[0] && rises_cur[0] >= 40) begin got = 1'b1; break; end
    end
    chk("rst40_reach", 32'(got), 32'd1);
    rst = 1'b1;
    d0 = done_total[0];
    tick();
    check_cleared("rst40");
    rst = 1'b0;
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      model_fs[i] = '0; model_fx[i] = '0; model_ref[i] = '0; model_ok[i] = '0;
    end
    ticks(20);
    chk("rst40_no_done", 32'(done_total[0] - d0), 32'd0);
    send_frame(0, rand_frame());
    wait_done(0, 3000);
    check_frame(0, "after_rst");

    // slowest divider
    send_frame(1, {32'($urandom()), 32'($urandom()), REF});
    wait_done(1, 52000);
    check_frame(1, "slow");

    // whole-run bus properties
    chk("idle_edges_fast", 32'(idle_edges[0]), 32'd0);
    chk("idle_edges_slow", 32'(idle_edges[1]), 32'd0);
    chk("done_align_fast", 32'(done_bad[0]), 32'd0);
    chk("done_align_slow", 32'(done_bad[1]), 32'd0);
    chk("busy_in_frame", 32'(busy_bad[0] + busy_bad[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
SPI master that reads the 96-bit measurement frame from the cymometer's SPI slave. The frame is fs_cnt, then fx_cnt, then the reference word, MSB first. The block generates nCS and SCK, samples MISO, and checks the reference word. It then presents the two counts as parallel outputs for the LCD1602 display/compute logic on the receiving board.

Parameters:
CLK_DIV, 8, SCK half-period in sys_clk cycles; legal range 8..255 (covers the slave's 2-FF SCK sync, its shift, and the local 2-FF MISO sync).
FRAME_BITS, 96, bits per frame; fixed at 3x32.
REF_WORD, 32'd200_000_000 (0x0BEBC200), expected third word.
IDLE_GAP, 16, minimum sys_clk cycles nCS stays high between frames; must be at least 1.

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  level; sampled only in IDLE, begins a frame
MISO  in  1  serial data from slave, asynchronous
nCS  out  1  chip select, active-low, registered
SCK  out  1  SPI clock, mode 0 (idle low), registered
busy  out  1  high from start acceptance through end of IDLE_GAP
done  out  1  one-cycle pulse when a frame completes
frame_ok  out  1  1 if the last frame's third word == REF_WORD
fs_cnt  out  32  first word of the last good frame
fx_cnt  out  32  second word of the last good frame
ref_cnt  out  32  third word of the last frame, good or not

Behaviour:
- Clock is sys_clk; reset is synchronous and active-high (rst).
- Reset values: nCS=1, SCK=0, busy=0, done=0, frame_ok=0, fs_cnt=fx_cnt=ref_cnt=0, shift register=0, bit counter=0, state=IDLE.
- rst overrides every other input on the same edge, including mid-frame. nCS goes high and SCK goes low on that edge; there is no partial-frame update.
- MISO passes through a 2-FF synchronizer (miso_s). All sampling uses miso_s.
- Counters: div_cnt counts 0..CLK_DIV-1; bit_cnt is 7 bits, 0..96; shift register is 96 bits, shifts left, and the new bit enters at bit 0.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE: nCS=1, SCK=0, busy=0. If start=1, go to SETUP on the next edge with nCS=0, busy=1, div_cnt=0, bit_cnt=0.
- SETUP: SCK=0 for CLK_DIV cycles. On the last cycle: SCK<=1, go to HIGH.
- HIGH: SCK=1 for CLK_DIV cycles. On the last cycle: shift in miso_s and increment bit_cnt.
  - If the new bit_cnt == 96: SCK<=0, go to HOLD.
  - Otherwise: SCK<=0, go to LOW.
- LOW: SCK=0 for CLK_DIV cycles. On the last cycle: SCK<=1, go to HIGH.
- HOLD: nCS=0, SCK=0 for CLK_DIV cycles. On the last cycle, all of the following happen on the same edge:
  - nCS<=1 and done<=1.
  - ref_cnt<=sr[31:0].
  - frame_ok<=(sr[31:0]==REF_WORD).
  - If that compare is true: fs_cnt<=sr[95:64] and fx_cnt<=sr[63:32]. Otherwise fs_cnt and fx_cnt hold.
  - Go to GAP.
- GAP: nCS=1, busy=1, done=0 after its first cycle. After IDLE_GAP cycles: busy<=0, go to IDLE.
- Frame timing: nCS-low duration = (1+96+95+1)*CLK_DIV = 193*CLK_DIV cycles. Exactly 96 SCK rising edges per frame.
- done is asserted on the edge where nCS returns high, i.e. 193*CLK_DIV cycles after nCS fell.
- start while not in IDLE is ignored. If start is held high, frames run back to back with exactly IDLE_GAP+1 cycles of nCS high between them (GAP plus one IDLE cycle).
- MISO sampling point is the last sys_clk cycle of the SCK high phase. The slave shifts on SCK falling edges, so its data has had CLK_DIV cycles to settle.
- Outputs fs_cnt, fx_cnt, ref_cnt, and frame_ok are stable between done pulses.

Test Plan:
1. Slave model (mode 0, MSB first, shifts on falling SCK, 2-FF SCK sync) sends fs=0x00001234, fx=0x00000ABC, ref=0x0BEBC200 with CLK_DIV=8 and a start pulse -> done exactly 1544 cycles after nCS falls; fs_cnt=0x00001234, fx_cnt=0x00000ABC, frame_ok=1; 96 SCK rising edges counted.
2. Good frame (as in 1), then a frame with ref=0x0BEBC1FF, fs=0xFFFFFFFF -> frame_ok=0, ref_cnt=0x0BEBC1FF, fs_cnt stays 0x00001234.
3. Bit-order check: fs=0xAAAAAAAA, fx=0x55555555, ref=REF_WORD -> outputs match exactly. Repeat with 0x80000001 / 0x00000001.
4. start held at 1 for 3 frames -> three done pulses; nCS high for exactly 17 cycles between frames (IDLE_GAP=16); busy low only in IDLE cycles. Extra start pulses during busy produce no extra frame.
5. rst asserted at the 40th SCK rise -> next edge gives nCS=1, SCK=0, busy=0, all data outputs 0, no done pulse. A following start yields a correct full frame.
6. CLK_DIV=255 -> nCS low for 49215 cycles; data correct; no SCK edges while nCS is high.
